// File: rtl/regfile_wb_scheduler_pkg.sv
// Shared constants and types for the register-file write-back scheduler.
// Requester indices follow the pipeline order ALU, MEM, FPU.
package regfile_wb_scheduler_pkg;

  localparam int NREQ    = 3;
  localparam int REQ_ALU = 0;
  localparam int REQ_MEM = 1;
  localparam int REQ_FPU = 2;
  localparam int ADDR_W  = 5;
  localparam int DATA_W  = 32;
  localparam int NREG    = 1 << ADDR_W;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_port_t;

endpackage

// File: rtl/regfile_wb_scheduler_if.sv
// Requester-side write-back bus: NREQ valid/ready channels with packed addr/data.
interface regfile_wb_scheduler_if
  import regfile_wb_scheduler_pkg::*;
#(
  parameter int NREQ = regfile_wb_scheduler_pkg::NREQ
);

  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0]        req_fp;
  logic [ADDR_W*NREQ-1:0] req_addr;
  logic [DATA_W*NREQ-1:0] req_data;
  logic [NREQ-1:0]        req_ready;

  modport master (
    output req_valid, req_fp, req_addr, req_data,
    input  req_ready
  );

  modport slave (
    input  req_valid, req_fp, req_addr, req_data,
    output req_ready
  );

endinterface

// File: rtl/regfile_wb_scheduler_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the pointer,
// then moves the pointer just past the winner.
module rr_arbiter
  import regfile_wb_scheduler_pkg::*;
#(
  parameter int NREQ = regfile_wb_scheduler_pkg::NREQ
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] grant
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] ptr_d;
  logic          found;
  int            idx;

  always_comb begin
    grant = '0;
    ptr_d = ptr_q;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        ptr_d      = PW'((idx + 1) % NREQ);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Write-back scheduler: independent round-robin arbitration for the GP and FP
// register files, one-cycle registered write ports and pending-write bitmaps.
module regfile_wb_scheduler
  import regfile_wb_scheduler_pkg::*;
#(
  parameter int NREQ = regfile_wb_scheduler_pkg::NREQ
) (
  input  logic                   clk,
  input  logic                   rst,
  regfile_wb_scheduler_if.slave  wb,
  output logic                   gp_we,
  output logic [ADDR_W-1:0]      gp_daddr,
  output logic [DATA_W-1:0]      gp_rd,
  output logic                   fp_we,
  output logic [ADDR_W-1:0]      fp_daddr,
  output logic [DATA_W-1:0]      fp_fd,
  input  logic                   iss_valid,
  input  logic                   iss_fp,
  input  logic [ADDR_W-1:0]      iss_addr,
  output logic [NREG-1:0]        busy_gp,
  output logic [NREG-1:0]        busy_fp
);

  logic [NREQ-1:0]   gnt_gp;
  logic [NREQ-1:0]   gnt_fp;
  logic              gp_acc_p0;
  logic              fp_acc_p0;
  logic [ADDR_W-1:0] gp_addr_p0;
  logic [ADDR_W-1:0] fp_addr_p0;
  logic [DATA_W-1:0] gp_data_p0;
  logic [DATA_W-1:0] fp_data_p0;
  logic [NREG-1:0]   busy_gp_d;
  logic [NREG-1:0]   busy_fp_d;
  wb_port_t          gp_p1;
  wb_port_t          fp_p1;

  rr_arbiter #(.NREQ(NREQ)) u_arb_gp (
    .clk   (clk),
    .rst   (rst),
    .req   (wb.req_valid & ~wb.req_fp),
    .grant (gnt_gp)
  );

  rr_arbiter #(.NREQ(NREQ)) u_arb_fp (
    .clk   (clk),
    .rst   (rst),
    .req   (wb.req_valid & wb.req_fp),
    .grant (gnt_fp)
  );

  assign wb.req_ready = rst ? '0 : (gnt_gp | gnt_fp);

  // p0: select the granted requester for each file
  always_comb begin
    gp_acc_p0  = !rst && (|gnt_gp);
    fp_acc_p0  = !rst && (|gnt_fp);
    gp_addr_p0 = '0;
    fp_addr_p0 = '0;
    gp_data_p0 = '0;
    fp_data_p0 = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_gp[i]) begin
        gp_addr_p0 = wb.req_addr[i*ADDR_W +: ADDR_W];
        gp_data_p0 = wb.req_data[i*DATA_W +: DATA_W];
      end
      if (gnt_fp[i]) begin
        fp_addr_p0 = wb.req_addr[i*ADDR_W +: ADDR_W];
        fp_data_p0 = wb.req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Clear on accept first so a same-cycle issue to the same register wins.
  always_comb begin
    busy_gp_d = busy_gp;
    busy_fp_d = busy_fp;
    if (gp_acc_p0) busy_gp_d[gp_addr_p0] = 1'b0;
    if (fp_acc_p0) busy_fp_d[fp_addr_p0] = 1'b0;
    if (iss_valid) begin
      if (iss_fp) busy_fp_d[iss_addr] = 1'b1;
      else        busy_gp_d[iss_addr] = 1'b1;
    end
    busy_gp_d[0] = 1'b0;
  end

  // p1: registered write ports and bitmaps; GP r0 is accepted but never written
  always_ff @(posedge clk) begin
    if (rst) begin
      gp_p1   <= '0;
      fp_p1   <= '0;
      busy_gp <= '0;
      busy_fp <= '0;
    end else begin
      gp_p1.we <= gp_acc_p0 && (gp_addr_p0 != '0);
      if (gp_acc_p0 && (gp_addr_p0 != '0)) begin
        gp_p1.addr <= gp_addr_p0;
        gp_p1.data <= gp_data_p0;
      end
      fp_p1.we <= fp_acc_p0;
      if (fp_acc_p0) begin
        fp_p1.addr <= fp_addr_p0;
        fp_p1.data <= fp_data_p0;
      end
      busy_gp <= busy_gp_d;
      busy_fp <= busy_fp_d;
    end
  end

  assign gp_we    = gp_p1.we;
  assign gp_daddr = gp_p1.addr;
  assign gp_rd    = gp_p1.data;
  assign fp_we    = fp_p1.we;
  assign fp_daddr = fp_p1.addr;
  assign fp_fd    = fp_p1.data;

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Directed and randomized bench for regfile_wb_scheduler against a
// cycle-level behavioural model of the arbitration and bitmap rules.
module tb_regfile_wb_scheduler;
  import regfile_wb_scheduler_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  regfile_wb_scheduler_if #(.NREQ(NREQ)) ifc ();

  logic [2:0]  v, f;
  logic [4:0]  a [3];
  logic [31:0] d [3];
  logic        iss_v, iss_f;
  logic [4:0]  iss_a;
  logic        gp_we, fp_we;
  logic [4:0]  gp_daddr, fp_daddr;
  logic [31:0] gp_rd, fp_fd, busy_gp, busy_fp;

  assign ifc.req_valid = v;
  assign ifc.req_fp    = f;
  assign ifc.req_addr  = {a[2], a[1], a[0]};
  assign ifc.req_data  = {d[2], d[1], d[0]};

  regfile_wb_scheduler dut (
    .clk       (clk),
    .rst       (rst),
    .wb        (ifc),
    .gp_we     (gp_we),
    .gp_daddr  (gp_daddr),
    .gp_rd     (gp_rd),
    .fp_we     (fp_we),
    .fp_daddr  (fp_daddr),
    .fp_fd     (fp_fd),
    .iss_valid (iss_v),
    .iss_fp    (iss_f),
    .iss_addr  (iss_a),
    .busy_gp   (busy_gp),
    .busy_fp   (busy_fp)
  );

  // Reference model state: index 0 = GP file, 1 = FP file
  int          ptr [2];
  logic [31:0] mbusy [2];
  logic        mwe [2];
  logic [4:0]  maddr [2];
  logic [31:0] mdata [2];
  logic [2:0]  obs_ready;
  logic [2:0]  last_acc;
  int          nerr = 0;
  int          nchk = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: check the grant before the edge, advance the model, check registers after.
  task automatic cycle();
    logic [2:0] er;
    int g [2];
    #1;
    er   = '0;
    g[0] = -1;
    g[1] = -1;
    if (!rst) begin
      for (int fl = 0; fl < 2; fl++) begin
        for (int k = 0; k < 3; k++) begin
          int idx;
          idx = (ptr[fl] + k) % 3;
          if (g[fl] < 0 && v[idx] && int'(f[idx]) == fl) begin
            g[fl]   = idx;
            er[idx] = 1'b1;
          end
        end
      end
    end
    obs_ready = ifc.req_ready;
    chk("req_ready", 32'(obs_ready), 32'(er));
    if (rst) begin
      for (int fl = 0; fl < 2; fl++) begin
        ptr[fl] = 0; mbusy[fl] = '0; mwe[fl] = 1'b0; maddr[fl] = '0; mdata[fl] = '0;
      end
    end else begin
      for (int fl = 0; fl < 2; fl++) begin
        mwe[fl] = 1'b0;
        if (g[fl] >= 0) begin
          ptr[fl] = (g[fl] + 1) % 3;
          mbusy[fl][a[g[fl]]] = 1'b0;
          if (!(fl == 0 && a[g[fl]] == 5'd0)) begin
            mwe[fl]   = 1'b1;
            maddr[fl] = a[g[fl]];
            mdata[fl] = d[g[fl]];
          end
        end
      end
      if (iss_v) mbusy[iss_f][iss_a] = 1'b1;
      mbusy[0][0] = 1'b0;
    end
    last_acc = er;
    @(posedge clk);
    #1;
    chk("gp_we",    32'(gp_we),    32'(mwe[0]));
    chk("gp_daddr", 32'(gp_daddr), 32'(maddr[0]));
    chk("gp_rd",    gp_rd,         mdata[0]);
    chk("fp_we",    32'(fp_we),    32'(mwe[1]));
    chk("fp_daddr", 32'(fp_daddr), 32'(maddr[1]));
    chk("fp_fd",    fp_fd,         mdata[1]);
    chk("busy_gp",  busy_gp,       mbusy[0]);
    chk("busy_fp",  busy_fp,       mbusy[1]);
  endtask

  initial begin
    rst = 1'b1; v = '0; f = '0; iss_v = 1'b0; iss_f = 1'b0; iss_a = '0;
    for (int i = 0; i < 3; i++) begin a[i] = '0; d[i] = '0; end
    last_acc = '0;

    // reset state
    cycle();
    cycle();
    chk("rst_gp_we", 32'(gp_we), 32'd0);
    chk("rst_busy_gp", busy_gp, 32'd0);
    rst = 1'b0;
    cycle();
    chk("post_rst_idle", 32'({gp_we, fp_we}), 32'd0);

    // three GP requesters held continuously
    v = 3'b111; f = 3'b000;
    a[REQ_ALU] = 5'd5; a[REQ_MEM] = 5'd6; a[REQ_FPU] = 5'd7;
    d[REQ_ALU] = 32'hA0A0_0005; d[REQ_MEM] = 32'hB0B0_0006; d[REQ_FPU] = 32'hC0C0_0007;
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk("rr_grant", 32'(obs_ready), 32'(1 << k));
      chk("rr_we", 32'(gp_we), 32'd1);
      chk("rr_daddr", 32'(gp_daddr), 32'(5 + k));
    end
    v = '0;
    cycle();
    chk("rr_we_end", 32'(gp_we), 32'd0);

    // simultaneous GP and FP transfers
    v = 3'b101; f = 3'b100;
    a[REQ_ALU] = 5'd3; d[REQ_ALU] = 32'h1111_1111;
    a[REQ_FPU] = 5'd3; d[REQ_FPU] = 32'h4049_0FDB;
    cycle();
    chk("dual_ready", 32'(obs_ready), 32'b101);
    chk("dual_gp", {gp_we, 26'd0, gp_daddr}, {1'b1, 26'd0, 5'd3});
    chk("dual_gp_rd", gp_rd, 32'h1111_1111);
    chk("dual_fp", {fp_we, 26'd0, fp_daddr}, {1'b1, 26'd0, 5'd3});
    chk("dual_fp_fd", fp_fd, 32'h4049_0FDB);
    v = '0; f = '0;

    // issue r8, MEM writes r8 two cycles later
    iss_v = 1'b1; iss_f = 1'b0; iss_a = 5'd8;
    cycle();
    iss_v = 1'b0;
    chk("busy8_set", 32'(busy_gp[8]), 32'd1);
    cycle();
    chk("busy8_hold", 32'(busy_gp[8]), 32'd1);
    v = 3'b010; a[REQ_MEM] = 5'd8; d[REQ_MEM] = 32'h0000_0888;
    cycle();
    chk("busy8_clr", 32'(busy_gp[8]), 32'd0);
    v = '0;

    // issue and accept r9 in the same cycle: set wins
    iss_v = 1'b1; iss_a = 5'd9;
    v = 3'b001; a[REQ_ALU] = 5'd9; d[REQ_ALU] = 32'h0000_0999;
    cycle();
    chk("busy9_setwins", 32'(busy_gp[9]), 32'd1);
    v = '0;

    // GP r0: never busy, accepted, never written
    iss_a = 5'd0;
    cycle();
    iss_v = 1'b0;
    chk("busy0_issue", 32'(busy_gp[0]), 32'd0);
    v = 3'b001; a[REQ_ALU] = 5'd0; d[REQ_ALU] = 32'hFFFF_FFFF;
    cycle();
    chk("r0_ready", 32'(obs_ready[0]), 32'd1);
    chk("r0_we", 32'(gp_we), 32'd0);
    chk("r0_busy", 32'(busy_gp[0]), 32'd0);
    v = '0;

    // reset with pending requests and FP bitmap 0x0000F000
    iss_v = 1'b1; iss_f = 1'b1;
    for (int r = 12; r < 16; r++) begin
      iss_a = 5'(r);
      cycle();
    end
    iss_v = 1'b0; iss_f = 1'b0;
    chk("busy_fp_fill", busy_fp, 32'h0000_F000);
    v = 3'b111; f = 3'b000;
    a[REQ_ALU] = 5'd10; a[REQ_MEM] = 5'd11; a[REQ_FPU] = 5'd12;
    cycle();
    rst = 1'b1;
    cycle();
    chk("rst_ready", 32'(obs_ready), 32'd0);
    chk("rst_ports", {gp_we, fp_we, 20'd0, gp_daddr, fp_daddr}, 32'd0);
    chk("rst_data", gp_rd | fp_fd, 32'd0);
    chk("rst_busy", busy_gp | busy_fp, 32'd0);
    rst = 1'b0;
    cycle();
    chk("restart_alu", 32'(obs_ready), 32'b001);
    v = '0;

    // randomized traffic with occasional reset
    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(0, 49) == 0);
      for (int i = 0; i < 3; i++) begin
        if (!v[i] || last_acc[i]) begin
          v[i] = ($urandom_range(0, 3) != 0);
          f[i] = 1'($urandom_range(0, 1));
          a[i] = 5'($urandom_range(0, 7));
          d[i] = $urandom;
        end
      end
      iss_v = 1'($urandom_range(0, 1));
      iss_f = 1'($urandom_range(0, 1));
      iss_a = 5'($urandom_range(0, 7));
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/regfile_wb_scheduler.md
REGFILE_WB_SCHEDULER -- requirements
Module: regfile_wb_scheduler

Interface
REQ-001 Parameter: NREQ, default 3, number of write-back requesters (index 0 = ALU, 1 = MEM, 2 = FPU).
REQ-002 Port: clk  in  1  sole clock; all state updates on rising edge.
REQ-003 Port: rst  in  1  synchronous, active-high reset.
REQ-004 Port: req_valid  in  NREQ  requester i holds a write-back result.
REQ-005 Port: req_fp  in  NREQ  1 = target is the FP file, 0 = target is the GP file.
REQ-006 Port: req_addr  in  5*NREQ  destination register, slice i = bits [5i+4:5i].
REQ-007 Port: req_data  in  32*NREQ  result data, slice i = bits [32i+31:32i].
REQ-008 Port: req_ready  out  NREQ  combinational grant; a transfer occurs when valid and ready are both high.
REQ-009 Port: gp_we / gp_daddr / gp_rd  out  1/5/32  registered GP write port.
REQ-010 Port: fp_we / fp_daddr / fp_fd  out  1/5/32  registered FP write port.
REQ-011 Port: iss_valid / iss_fp / iss_addr  in  1/1/5  issue stage marks a destination as pending.
REQ-012 Port: busy_gp / busy_fp  out  32/32  pending-write bitmaps, one bit per register.

Function
REQ-013 The GP and FP files SHALL be arbitrated independently, with at most one grant per file per cycle and up to two grants in total.
REQ-014 Each file SHALL use round-robin arbitration; the requester with the highest priority is the first valid requester at or after that file's pointer.
REQ-015 After a grant, that file's pointer SHALL move to (granted index + 1) mod NREQ; with no grant, the pointer SHALL hold.
REQ-016 req_ready[i] SHALL depend only on req_valid, req_fp and the pointers, never on req_data.
REQ-017 req_ready[i] SHALL be 0 whenever req_valid[i] is 0.
REQ-018 Requesters SHALL hold valid, fp, addr and data stable until they are accepted; the scheduler does not check this.
REQ-019 An accepted transfer SHALL drive the matching write port on the next cycle, a latency of exactly 1, with we high for one cycle.
REQ-020 In a cycle with no accept for a file, that file's we SHALL be 0; daddr and data SHALL hold their last values.
REQ-021 A GP transfer to register 0 SHALL be accepted normally, with gp_we kept at 0 on the following cycle.
REQ-022 An FP transfer to register 0 SHALL be written normally.
REQ-023 When iss_valid is high, the busy bit selected by iss_fp and iss_addr SHALL be set on the next edge.
REQ-024 busy_gp[0] SHALL never be set.
REQ-025 An accepted transfer SHALL clear the busy bit for its file and address on the next edge.
REQ-026 If an issue and an accept hit the same file and address in the same cycle, the set SHALL win.
REQ-027 An issue to a register that is already busy (WAW) SHALL leave its bit set; the first matching write clears it.
REQ-028 Bitmaps SHALL be registered outputs that update the cycle after the event, not in the same cycle.
REQ-029 A requester whose valid is high with no grant SHALL keep its request; an unchanged valid requester SHALL wait no more than NREQ-1 cycles.

Reset
REQ-030 While rst is high, req_ready, gp_we and fp_we SHALL be 0, and no transfers or issues are recorded.
REQ-031 While rst is high, gp_daddr, gp_rd, fp_daddr, fp_fd, busy_gp and busy_fp SHALL be 0.
REQ-032 While rst is high, both round-robin pointers SHALL be 0.
REQ-033 Reset mid-operation SHALL discard any pending write-port output.
REQ-034 On the first cycle after rst falls, the write ports SHALL be idle.

Structure
REQ-035 A shared package SHALL hold NREQ, the requester index constants (REQ_ALU, REQ_MEM, REQ_FPU), the 5-bit address width and the 32-bit data width.
REQ-036 The round-robin arbiter SHALL be one sub-module, rr_arbiter (NREQ inputs, one-hot grant, internal pointer), instantiated once for GP and once for FP.

Verification
REQ-037 Bench: after reset, ALU, MEM and FPU each hold GP writes to r5/r6/r7 continuously -> grants ALU, MEM, FPU in order, one per cycle; gp_we high for 3 consecutive cycles, starting one cycle after the first grant.
REQ-038 Bench: ALU writes GP r3 = 0x11111111 and FPU writes FP f3 = 0x40490FDB in the same cycle -> both ready; next cycle gp_we=1/gp_daddr=3 and fp_we=1/fp_daddr=3 with the matching data.
REQ-039 Bench: issue GP r8, then 2 cycles later MEM writes r8 -> busy_gp[8] is 1 from the cycle after issue until the cycle after accept.
REQ-040 Bench: issue GP r9 and accept a GP write to r9 in the same cycle -> busy_gp[9] = 1 afterwards.
REQ-041 Bench: issue GP r0, then ALU writes r0 = 0xFFFFFFFF -> busy_gp stays 0, req_ready[0] = 1, gp_we stays 0.
REQ-042 Bench: assert rst while 3 requests are pending and busy_fp = 0x0000F000 -> next cycle all outputs are 0; after release, arbitration restarts at ALU.
